// File: rtl/riscv_soft_dmem_ctrl_if.sv
// Core-side and memory-side bundles for riscv_soft_dmem_ctrl.
// dc: core load/store request + completion; mem: word-wide single-outstanding bus.
interface riscv_soft_dmem_dc_if #(
    parameter int XPR_LEN = 32
);
    logic               d_cache_req_valid;
    logic               d_cache_req_ready;
    logic [1:0]         d_cache_req_op;
    logic [2:0]         d_cache_req_op_type;
    logic [XPR_LEN-1:0] d_cache_req_addr;
    logic [XPR_LEN-1:0] d_cache_req_data;
    logic               d_cache_resp_valid;
    logic [XPR_LEN-1:0] d_cache_resp_data;
    logic               d_cache_resp_error;

    modport master (
        output d_cache_req_valid,
        output d_cache_req_op,
        output d_cache_req_op_type,
        output d_cache_req_addr,
        output d_cache_req_data,
        input  d_cache_req_ready,
        input  d_cache_resp_valid,
        input  d_cache_resp_data,
        input  d_cache_resp_error
    );

    modport slave (
        input  d_cache_req_valid,
        input  d_cache_req_op,
        input  d_cache_req_op_type,
        input  d_cache_req_addr,
        input  d_cache_req_data,
        output d_cache_req_ready,
        output d_cache_resp_valid,
        output d_cache_resp_data,
        output d_cache_resp_error
    );
endinterface

interface riscv_soft_dmem_mem_if #(
    parameter int XPR_LEN = 32
);
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic               mem_req_we;
    logic [XPR_LEN-1:0] mem_req_addr;
    logic [3:0]         mem_req_wmask;
    logic [XPR_LEN-1:0] mem_req_wdata;
    logic               mem_resp_valid;
    logic [XPR_LEN-1:0] mem_resp_data;

    modport master (
        output mem_req_valid,
        output mem_req_we,
        output mem_req_addr,
        output mem_req_wmask,
        output mem_req_wdata,
        input  mem_req_ready,
        input  mem_resp_valid,
        input  mem_resp_data
    );

    modport slave (
        input  mem_req_valid,
        input  mem_req_we,
        input  mem_req_addr,
        input  mem_req_wmask,
        input  mem_req_wdata,
        output mem_req_ready,
        output mem_resp_valid,
        output mem_resp_data
    );
endinterface

// File: rtl/riscv_soft_dmem_ctrl.sv
// Data-memory controller: one load/store at a time from the core onto a word bus.
// Ports: clk, reset (async active-low), dc (core side, slave), mem (memory side, master).
module riscv_soft_dmem_ctrl #(
    parameter int XPR_LEN = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    riscv_soft_dmem_dc_if.slave   dc,
    riscv_soft_dmem_mem_if.master mem
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_MEM_REQ,
        S_MEM_WAIT,
        S_RESP
    } state_e;

    localparam logic [1:0] OP_LD = 2'b01;
    localparam logic [1:0] OP_ST = 2'b10;

    state_e             state_q, state_d;
    logic [2:0]         f3_q, f3_d;
    logic [1:0]         off_q, off_d;
    logic               resp_valid_q, resp_valid_d;
    logic               resp_err_q, resp_err_d;
    logic [XPR_LEN-1:0] resp_data_q, resp_data_d;
    logic               mreq_valid_q, mreq_valid_d;
    logic               mreq_we_q, mreq_we_d;
    logic [XPR_LEN-1:0] mreq_addr_q, mreq_addr_d;
    logic [3:0]         mreq_wmask_q, mreq_wmask_d;
    logic [XPR_LEN-1:0] mreq_wdata_q, mreq_wdata_d;

    logic               is_ld;
    logic               is_st;
    logic               legal;
    logic               misal;
    logic [3:0]         st_wmask;
    logic [XPR_LEN-1:0] st_wdata;
    logic [XPR_LEN-1:0] ld_shift;
    logic [XPR_LEN-1:0] ld_ext;

    // Request decode: legality, alignment and store lane placement.
    always_comb begin
        is_ld = (dc.d_cache_req_op == OP_LD);
        is_st = (dc.d_cache_req_op == OP_ST);

        legal = 1'b0;
        unique case (dc.d_cache_req_op_type)
            3'b000, 3'b001, 3'b010: legal = is_ld | is_st;
            3'b100, 3'b101:         legal = is_ld;
            default:                legal = 1'b0;
        endcase

        misal = 1'b0;
        unique case (dc.d_cache_req_op_type[1:0])
            2'b01:   misal = dc.d_cache_req_addr[0];
            2'b10:   misal = |dc.d_cache_req_addr[1:0];
            default: misal = 1'b0;
        endcase

        st_wmask = 4'b1111;
        st_wdata = dc.d_cache_req_data;
        unique case (dc.d_cache_req_op_type[1:0])
            2'b00: begin
                st_wmask = 4'b0001 << dc.d_cache_req_addr[1:0];
                st_wdata = {4{dc.d_cache_req_data[7:0]}};
            end
            2'b01: begin
                st_wmask = 4'b0011 << dc.d_cache_req_addr[1:0];
                st_wdata = {2{dc.d_cache_req_data[15:0]}};
            end
            default: begin
                st_wmask = 4'b1111;
                st_wdata = dc.d_cache_req_data;
            end
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then extend.
    always_comb begin
        ld_shift = mem.mem_resp_data >> {off_q, 3'b000};
        ld_ext   = ld_shift;
        unique case (f3_q)
            3'b000:  ld_ext = {{(XPR_LEN-8){ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{(XPR_LEN-16){ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_ext = {{(XPR_LEN-8){1'b0}}, ld_shift[7:0]};
            3'b101:  ld_ext = {{(XPR_LEN-16){1'b0}}, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        f3_d         = f3_q;
        off_d        = off_q;
        resp_valid_d = 1'b0;
        resp_err_d   = resp_err_q;
        resp_data_d  = resp_data_q;
        mreq_valid_d = mreq_valid_q;
        mreq_we_d    = mreq_we_q;
        mreq_addr_d  = mreq_addr_q;
        mreq_wmask_d = mreq_wmask_q;
        mreq_wdata_d = mreq_wdata_q;

        unique case (state_q)
            S_IDLE: begin
                if (dc.d_cache_req_valid && (is_ld || is_st)) begin
                    f3_d  = dc.d_cache_req_op_type;
                    off_d = dc.d_cache_req_addr[1:0];
                    if (!legal || misal) begin
                        // Rejected without touching the bus.
                        state_d      = S_RESP;
                        resp_valid_d = 1'b1;
                        resp_err_d   = 1'b1;
                        resp_data_d  = '0;
                    end else begin
                        state_d      = S_MEM_REQ;
                        mreq_valid_d = 1'b1;
                        mreq_we_d    = is_st;
                        mreq_addr_d  = {dc.d_cache_req_addr[XPR_LEN-1:2], 2'b00};
                        mreq_wmask_d = is_st ? st_wmask : 4'b0000;
                        mreq_wdata_d = is_st ? st_wdata : '0;
                    end
                end
            end
            S_MEM_REQ: begin
                if (mem.mem_req_ready) begin
                    state_d      = S_MEM_WAIT;
                    mreq_valid_d = 1'b0;
                end
            end
            S_MEM_WAIT: begin
                if (mem.mem_resp_valid) begin
                    state_d      = S_RESP;
                    resp_valid_d = 1'b1;
                    resp_err_d   = 1'b0;
                    resp_data_d  = mreq_we_q ? '0 : ld_ext;
                end
            end
            S_RESP: begin
                state_d     = S_IDLE;
                resp_err_d  = 1'b0;
                resp_data_d = '0;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            f3_q         <= 3'b000;
            off_q        <= 2'b00;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            mreq_valid_q <= 1'b0;
            mreq_we_q    <= 1'b0;
            mreq_addr_q  <= '0;
            mreq_wmask_q <= 4'b0000;
            mreq_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            f3_q         <= f3_d;
            off_q        <= off_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_data_q  <= resp_data_d;
            mreq_valid_q <= mreq_valid_d;
            mreq_we_q    <= mreq_we_d;
            mreq_addr_q  <= mreq_addr_d;
            mreq_wmask_q <= mreq_wmask_d;
            mreq_wdata_q <= mreq_wdata_d;
        end
    end

    assign dc.d_cache_req_ready  = (state_q == S_IDLE);
    assign dc.d_cache_resp_valid = resp_valid_q;
    assign dc.d_cache_resp_error = resp_err_q;
    assign dc.d_cache_resp_data  = resp_data_q;
    assign mem.mem_req_valid     = mreq_valid_q;
    assign mem.mem_req_we        = mreq_we_q;
    assign mem.mem_req_addr      = mreq_addr_q;
    assign mem.mem_req_wmask     = mreq_wmask_q;
    assign mem.mem_req_wdata     = mreq_wdata_q;
endmodule
